camera_capture_ctrl: RTL and testbench
======================================

// Module: camera_capture_ctrl
// PURPOSE
//  Frame-capture sequencer behind the camera RGB565 interface, in the i_clk_pixel domain.
//  - Arms on software command, locks to frame start, optionally decimates frames.
//  - Gates the pixel stream into a valid/ready output with SOF/EOL markers.
//  - Checks frame geometry and reports sticky size/overflow errors.
// PARAMETERS
//  H_ACTIVE   1280  expected pixels per line
//  V_ACTIVE   720   expected lines per frame
//  CNT_W      12    width of pixel/line counters (>= clog2(max(H,V))+1)
//  VSYNC_POL  1     1: vsync active-high; 0: active-low
// PORTS
//  i_clk_pixel      in   1     pixel clock
//  i_rstn           in   1     async active-low reset
//  i_rgb565_vde     in   1     pixel valid (one cycle per pixel)
//  i_rgb565_vsync   in   1     frame sync
//  i_rgb565_data    in   16    RGB565 pixel
//  i_cap_enable     in   1     level: continuous capture
//  i_cap_single     in   1     pulse: capture exactly one frame
//  i_frame_skip     in   4     frames discarded before each captured frame
//  i_err_clr        in   1     pulse: clear sticky errors
//  o_tdata          out  16    pixel out
//  o_tvalid         out  1     pixel valid
//  i_tready         in   1     downstream accept
//  o_tuser          out  1     SOF: first pixel of frame
//  o_tlast          out  1     EOL: last pixel of line
//  o_busy           out  1     state != IDLE
//  o_frame_done     out  1     1-cycle pulse on completed frame
//  o_frame_cnt      out  16    completed-frame count, wraps
//  o_err_size       out  1     sticky geometry error
//  o_err_ovf        out  1     sticky output overflow
//  o_meas_width     out  CNT_W measured width (see CONFIGURATION)
//  o_meas_height    out  CNT_W measured height (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; counters, skip count, single flag cleared.
//  - SOF event: vsync reg transitions inactive->active per VSYNC_POL.
//  - Edge detect: one input register stage.
//  - FSM:
//    IDLE: i_cap_enable=1 or i_cap_single=1 -> WAIT_SOF; single latches one-shot flag.
//    WAIT_SOF: on SOF, skip_cnt<i_frame_skip -> skip_cnt++ and stay; else skip_cnt=0,
//      clear pix/line counters, -> CAPTURE.
//    CAPTURE: every vde cycle emits a pixel; pix++.
//      vde falling edge = end of line: pix!=H_ACTIVE -> err_size; line++, pix=0.
//      End of line V_ACTIVE-1: o_frame_done pulse; frame_cnt++.
//      Then IDLE if single flag set or i_cap_enable=0 (flag cleared), else WAIT_SOF.
//  - Output latency: 1 cycle vde->o_tvalid, via a 1-entry holding register.
//  - o_tuser=1 iff pix==0 && line==0; o_tlast=1 iff pix==H_ACTIVE-1.
//  - Held pixel stays valid until i_tready=1.
//  - New pixel while held one unaccepted: held pixel replaced, err_ovf set.
//    Counters still advance, keeping SOF/EOL aligned.
//  - Pixels past H_ACTIVE-1 in a line, or any pixel on line >= V_ACTIVE:
//    suppressed (no tvalid), err_size set.
//  - SOF while in CAPTURE (short frame): err_size set; counters cleared; capture restarts.
//    No skip applied; no frame_done.
//  - i_cap_enable dropped mid-frame: current frame completes, then IDLE.
//  - i_cap_single while busy: ignored.
//  - i_err_clr with simultaneous error set: set wins.
//  - Async reset mid-frame: immediate return to reset state.
// CONFIGURATION
//  Macro CAPTURE_STATS_EN:
//  - Defined: free-running width/height measurement in every state.
//    Width = vde count of the last line; height = line count.
//    o_meas_width/o_meas_height latched on each SOF event.
//  - Undefined: measurement logic omitted; both ports driven 0.
// TESTING  (bench params H_ACTIVE=8, V_ACTIVE=4, i_tready=1 unless stated)
//  - cap_single, skip=0, one 8x4 frame:
//    32 tvalid beats; tuser on beat 0 only; tlast on beats 7,15,23,31.
//    frame_done once; frame_cnt=1; FSM back in IDLE.
//  - cap_enable=1, skip=2, 6 frames: frames 3 and 6 captured; frame_cnt=2; no errors.
//  - Line of 7 pixels in frame: err_size=1; pixels still forwarded.
//    err_clr -> 0 next cycle.
//  - SOF after 2 lines: err_size=1; capture restarts.
//    Next full frame gives 32 beats and frame_done.
//  - i_tready=0 across 2 pixels: err_ovf=1; held data = second pixel; tlast position unchanged.
//  - Reset asserted mid-frame: all outputs 0 at once; after release, no output until a new command.

Source files
------------

// File: rtl/camera_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : camera_capture_ctrl
// Brief    : Frame-capture sequencer for an RGB565 camera stream (pixel clock
//            domain). Optional measurement logic enabled by CAPTURE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module camera_capture_ctrl #(
    parameter int H_ACTIVE  = 1280,
    parameter int V_ACTIVE  = 720,
    parameter int CNT_W     = 12,
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic             i_clk_pixel,
    input  logic             i_rstn,
    input  logic             i_rgb565_vde,
    input  logic             i_rgb565_vsync,
    input  logic [15:0]      i_rgb565_data,
    input  logic             i_cap_enable,
    input  logic             i_cap_single,
    input  logic [3:0]       i_frame_skip,
    input  logic             i_err_clr,
    output logic [15:0]      o_tdata,
    output logic             o_tvalid,
    input  logic             i_tready,
    output logic             o_tuser,
    output logic             o_tlast,
    output logic             o_busy,
    output logic             o_frame_done,
    output logic [15:0]      o_frame_cnt,
    output logic             o_err_size,
    output logic             o_err_ovf,
    output logic [CNT_W-1:0] o_meas_width,
    output logic [CNT_W-1:0] o_meas_height
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_SOF = 2'd1,
        S_CAPTURE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_H      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] C_H_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] C_V      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] C_V_LAST = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] C_MAX    = '1;

    state_t           r_state;
    logic             r_single;
    logic [3:0]       r_skip_cnt;
    logic [CNT_W-1:0] r_pix;
    logic [CNT_W-1:0] r_line;
    logic             r_vde;
    logic             r_vs_act;

    logic w_vs_act;
    logic w_sof;
    logic w_eol;
    logic w_pix_ok;

    assign w_vs_act = VSYNC_POL ? i_rgb565_vsync : ~i_rgb565_vsync;
    assign w_sof    = w_vs_act & ~r_vs_act;
    assign w_eol    = r_vde & ~i_rgb565_vde;
    assign w_pix_ok = (r_pix < C_H) && (r_line < C_V);

    always_ff @(posedge i_clk_pixel or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state      <= S_IDLE;
            r_single     <= 1'b0;
            r_skip_cnt   <= 4'd0;
            r_pix        <= '0;
            r_line       <= '0;
            r_vde        <= 1'b0;
            r_vs_act     <= 1'b0;
            o_tdata      <= 16'd0;
            o_tvalid     <= 1'b0;
            o_tuser      <= 1'b0;
            o_tlast      <= 1'b0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_cnt  <= 16'd0;
            o_err_size   <= 1'b0;
            o_err_ovf    <= 1'b0;
        end else begin
            r_vde        <= i_rgb565_vde;
            r_vs_act     <= w_vs_act;
            o_frame_done <= 1'b0;
            // Clear comes first so any error raised this cycle overrides it
            if (i_err_clr) begin
                o_err_size <= 1'b0;
                o_err_ovf  <= 1'b0;
            end
            if (o_tvalid && i_tready) begin
                o_tvalid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_cap_enable || i_cap_single) begin
                        r_state  <= S_WAIT_SOF;
                        r_single <= i_cap_single;
                        o_busy   <= 1'b1;
                    end
                end
                S_WAIT_SOF: begin
                    if (w_sof) begin
                        if (r_skip_cnt < i_frame_skip) begin
                            r_skip_cnt <= r_skip_cnt + 4'd1;
                        end else begin
                            r_skip_cnt <= 4'd0;
                            r_pix      <= '0;
                            r_line     <= '0;
                            r_state    <= S_CAPTURE;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (w_sof) begin
                        // Frame restarted before completion
                        o_err_size <= 1'b1;
                        r_pix      <= '0;
                        r_line     <= '0;
                    end else if (i_rgb565_vde) begin
                        if (w_pix_ok) begin
                            o_tvalid <= 1'b1;
                            o_tdata  <= i_rgb565_data;
                            o_tuser  <= (r_pix == '0) && (r_line == '0);
                            o_tlast  <= (r_pix == C_H_LAST);
                            if (o_tvalid && !i_tready) begin
                                o_err_ovf <= 1'b1;
                            end
                        end else begin
                            o_err_size <= 1'b1;
                        end
                        if (r_pix != C_MAX) begin
                            r_pix <= r_pix + 1'b1;
                        end
                    end else if (w_eol) begin
                        if (r_pix != C_H) begin
                            o_err_size <= 1'b1;
                        end
                        r_pix <= '0;
                        if (r_line != C_MAX) begin
                            r_line <= r_line + 1'b1;
                        end
                        if (r_line == C_V_LAST) begin
                            o_frame_done <= 1'b1;
                            o_frame_cnt  <= o_frame_cnt + 16'd1;
                            if (r_single || !i_cap_enable) begin
                                r_state  <= S_IDLE;
                                r_single <= 1'b0;
                                o_busy   <= 1'b0;
                            end else begin
                                r_state <= S_WAIT_SOF;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CAPTURE_STATS_EN
    logic [CNT_W-1:0] r_meas_pix;
    logic [CNT_W-1:0] r_meas_line;
    logic [CNT_W-1:0] r_last_width;

    always_ff @(posedge i_clk_pixel or negedge i_rstn) begin
        if (!i_rstn) begin
            r_meas_pix    <= '0;
            r_meas_line   <= '0;
            r_last_width  <= '0;
            o_meas_width  <= '0;
            o_meas_height <= '0;
        end else begin
            if (i_rgb565_vde && (r_meas_pix != C_MAX)) begin
                r_meas_pix <= r_meas_pix + 1'b1;
            end
            if (w_eol) begin
                r_last_width <= r_meas_pix;
                r_meas_pix   <= '0;
                if (r_meas_line != C_MAX) begin
                    r_meas_line <= r_meas_line + 1'b1;
                end
            end
            if (w_sof) begin
                o_meas_width  <= r_last_width;
                o_meas_height <= r_meas_line;
                r_meas_line   <= '0;
            end
        end
    end
`else
    assign o_meas_width  = '0;
    assign o_meas_height = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_camera_capture_ctrl.sv
`default_nettype none
// Testbench for camera_capture_ctrl: randomized frames against a frame-level
// reference model, plus literal checks for the directed scenarios.
module tb_camera_capture_ctrl;
    localparam int H = 8;
    localparam int V = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        vde = 1'b0, vs = 1'b0;
    logic [15:0] data = 16'd0;
    logic        en = 1'b0, single = 1'b0, clr = 1'b0, tready = 1'b1;
    logic [3:0]  skip = 4'd0;

    logic [15:0] tdata, frame_cnt;
    logic        tvalid, tuser, tlast, busy, frame_done, err_size, err_ovf;
    logic [11:0] meas_w, meas_h;

    always #5 clk = ~clk;

    camera_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(12), .VSYNC_POL(1'b1)) dut (
        .i_clk_pixel(clk), .i_rstn(rstn), .i_rgb565_vde(vde), .i_rgb565_vsync(vs),
        .i_rgb565_data(data), .i_cap_enable(en), .i_cap_single(single),
        .i_frame_skip(skip), .i_err_clr(clr), .o_tdata(tdata), .o_tvalid(tvalid),
        .i_tready(tready), .o_tuser(tuser), .o_tlast(tlast), .o_busy(busy),
        .o_frame_done(frame_done), .o_frame_cnt(frame_cnt), .o_err_size(err_size),
        .o_err_ovf(err_ovf), .o_meas_width(meas_w), .o_meas_height(meas_h)
    );

    int vectors = 0, miscompares = 0;

    // Reference model: mode 0 = idle, 1 = armed, 2 = capturing
    int          m_mode, m_skip, m_cnt;
    bit          m_single, m_tv, m_tu, m_tl, m_done, m_esz, m_eovf;
    logic [15:0] m_td;

    bit          chk_en = 0, rand_tready = 0, rand_clr = 0;
    int          beats, user_cnt, done_cnt;
    bit          user_bad;
    logic [31:0] last_mask;
    logic [15:0] last_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_skip = 0; m_cnt = 0; m_single = 0;
        m_tv = 0; m_tu = 0; m_tl = 0; m_td = '0; m_done = 0; m_esz = 0; m_eovf = 0;
    endtask

    task automatic model_step(input bit v, input bit sof, input bit eol,
                              input int x, input int y, input int len);
        bit emit;
        emit = 0;
        m_done = 0;
        if (clr) begin m_esz = 0; m_eovf = 0; end
        case (m_mode)
            0: if (en || single) begin m_mode = 1; m_single = single; end
            1: if (sof) begin
                   if (m_skip < int'(skip)) m_skip++;
                   else begin m_skip = 0; m_mode = 2; end
               end
            default: begin
                if (sof) m_esz = 1;
                else if (v) begin
                    if (x < H && y < V) emit = 1; else m_esz = 1;
                end else if (eol) begin
                    if (len != H) m_esz = 1;
                    if (y == V - 1) begin
                        m_done = 1;
                        m_cnt = (m_cnt + 1) % 65536;
                        if (m_single || !en) begin m_mode = 0; m_single = 0; end
                        else m_mode = 1;
                    end
                end
            end
        endcase
        if (emit) begin
            if (m_tv && !tready) m_eovf = 1;
            m_tv = 1; m_td = data; m_tu = (x == 0 && y == 0); m_tl = (x == H - 1);
        end else if (tready) begin
            m_tv = 0;
        end
    endtask

    task automatic cyc(input bit v, input bit s, input bit sof, input bit eol,
                       input int x, input int y, input int len);
        vde = v; vs = s;
        if (v) begin data = 16'($urandom); last_data = data; end
        if (rand_tready) tready = ($urandom_range(0, 3) != 0);
        if (rand_clr && $urandom_range(0, 15) == 0) clr = 1'b1;
        @(posedge clk);
        if (!rstn) model_reset();
        else model_step(v, sof, eol, x, y, len);
        #1;
        single = 1'b0; clr = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic send_frame(input int lines, input int short_y, input int drop_y, input int ovf_y);
        int len;
        gap(2);
        cyc(0, 1, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        gap(2);
        for (int y = 0; y < lines; y++) begin
            if (y == drop_y) en = 1'b0;
            len = (y == short_y) ? H - 1 : H;
            for (int x = 0; x < len; x++) begin
                if (y == ovf_y) tready = (x != H - 1);
                cyc(1, 0, 0, 0, x, y, 0);
            end
            if (y == ovf_y) tready = 1'b0;
            cyc(0, 0, 0, 1, 0, y, len);
            if (y == ovf_y) begin
                chk("ovf_held_data", tdata, last_data);
                chk("ovf_held_tlast", tlast, 1);
                chk("ovf_flag", err_ovf, 1);
                tready = 1'b1;
            end
            gap($urandom_range(1, 3));
        end
    endtask

    task automatic clear_counts();
        beats = 0; user_cnt = 0; done_cnt = 0; user_bad = 0; last_mask = '0;
    endtask

    always @(negedge clk) begin
        if (chk_en && rstn) begin
            chk("tvalid", tvalid, m_tv);
            if (m_tv) begin
                chk("tdata", tdata, m_td);
                chk("tuser", tuser, m_tu);
                chk("tlast", tlast, m_tl);
            end
            chk("busy", busy, (m_mode != 0));
            chk("frame_done", frame_done, m_done);
            chk("frame_cnt", frame_cnt, m_cnt);
            chk("err_size", err_size, m_esz);
            chk("err_ovf", err_ovf, m_eovf);
`ifndef CAPTURE_STATS_EN
            chk("meas", {meas_w, meas_h}, 0);
`endif
            if (tvalid && tready) begin
                if (tuser) begin user_cnt++; if (beats != 0) user_bad = 1; end
                if (tlast && beats < 32) last_mask[beats] = 1'b1;
                beats++;
            end
            if (frame_done) done_cnt++;
        end
    end

    initial begin
        model_reset();
        clear_counts();
        last_data = '0;
        gap(3);
        chk("reset_tvalid", tvalid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_cnt", frame_cnt, 0);
        chk("reset_errs", {err_size, err_ovf}, 0);
        rstn = 1'b1;
        chk_en = 1;
        gap(2);

        // One single-shot frame
        clear_counts();
        single = 1'b1; gap(1);
        send_frame(4, -1, -1, -1); gap(3);
        chk("t1_beats", beats, 32);
        chk("t1_user_cnt", user_cnt, 1);
        chk("t1_user_pos", user_bad, 0);
        chk("t1_tlast_mask", last_mask, 32'h8080_8080);
        chk("t1_done", done_cnt, 1);
        chk("t1_frame_cnt", frame_cnt, 1);
        chk("t1_idle", busy, 0);

        // Continuous capture with skip=2; enable dropped during the 6th frame
        clear_counts();
        skip = 4'd2; en = 1'b1; gap(1);
        for (int f = 0; f < 6; f++) send_frame(4, -1, (f == 5) ? 1 : -1, -1);
        gap(3);
        chk("t2_done", done_cnt, 2);
        chk("t2_beats", beats, 64);
        chk("t2_frame_cnt", frame_cnt, 3);
        chk("t2_errs", {err_size, err_ovf}, 0);
        chk("t2_idle", busy, 0);
        skip = 4'd0;

        // Short line in a frame
        clear_counts();
        single = 1'b1; gap(1);
        send_frame(4, 1, -1, -1); gap(3);
        chk("t3_err_size", err_size, 1);
        chk("t3_beats", beats, 31);
        chk("t3_frame_cnt", frame_cnt, 4);
        clr = 1'b1; gap(1);
        chk("t3_err_clr", err_size, 0);

        // Frame restarted after two lines
        single = 1'b1; gap(1);
        send_frame(2, -1, -1, -1); gap(3);
        chk("t4_still_busy", busy, 1);
        clear_counts();
        send_frame(4, -1, -1, -1); gap(3);
        chk("t4_err_size", err_size, 1);
        chk("t4_beats", beats, 32);
        chk("t4_done", done_cnt, 1);
        chk("t4_frame_cnt", frame_cnt, 5);
        clr = 1'b1; gap(1);

        // Back-pressure across the last two pixels of line 0
        clear_counts();
        single = 1'b1; gap(1);
        send_frame(4, -1, -1, 0); gap(3);
        chk("t5_beats", beats, 31);
        chk("t5_tlast_mask", last_mask, 32'h4040_4040);
        chk("t5_frame_cnt", frame_cnt, 6);
        clr = 1'b1; gap(1);

        // Randomized frames, back-pressure and error clears
        rand_tready = 1; rand_clr = 1;
        for (int r = 0; r < 3; r++) begin
            skip = 4'($urandom_range(0, 2));
            en = 1'b1; gap(1);
            for (int f = 0; f < 4; f++) begin
                send_frame(($urandom_range(0, 4) == 0) ? 2 : 4,
                           ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1,
                           (f == 3) ? 2 : -1, -1);
            end
            gap(4);
        end
        rand_tready = 0; rand_clr = 0; tready = 1'b1; skip = 4'd0;
        gap(3);

        // Asynchronous reset in the middle of a frame
        en = 1'b1; gap(1);
        fork
            send_frame(4, -1, -1, -1);
            begin
                repeat (30) @(posedge clk);
                #3;
                rstn = 1'b0; en = 1'b0;
                #1;
                chk("rst_tvalid", tvalid, 0);
                chk("rst_flags", {tuser, tlast, busy, frame_done, err_size, err_ovf}, 0);
                chk("rst_tdata", tdata, 0);
                chk("rst_frame_cnt", frame_cnt, 0);
                @(posedge clk); @(posedge clk);
                #2 rstn = 1'b1;
                clear_counts();
            end
        join
        send_frame(4, -1, -1, -1); gap(3);
        chk("t7_no_beats", beats, 0);
        chk("t7_idle", busy, 0);
        chk("t7_no_done", done_cnt, 0);

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
